// File: rtl/alu_pkg.sv
// Shared constants and types for the shared ALU arbiter slice.
package alu_pkg;

  localparam int unsigned ALU_W = 64;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_XOR = 2'd3;

  localparam int unsigned CC_W  = 3;
  localparam int unsigned CC_ZF = 2;
  localparam int unsigned CC_SF = 1;
  localparam int unsigned CC_OF = 0;

  // Result register occupancy.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Requester-id width, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between operand-fetch requesters and the shared ALU.
interface alu_share_arbiter_if #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned W     = alu_pkg::ALU_W
);
  localparam int unsigned IDW = alu_pkg::id_width(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [2*N_REQ-1:0] req_fun;
  logic [W*N_REQ-1:0] req_a;
  logic [W*N_REQ-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [W-1:0]       rsp_data;
  logic [2:0]         rsp_cc;

  modport master (
    output req_valid, req_fun, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_cc
  );

  modport slave (
    input  req_valid, req_fun, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_cc
  );

endinterface

// File: rtl/alu64_core.sv
// Combinational Y86 ALU: valE = b OP a with {ZF,SF,OF} condition codes.
module alu64_core
  import alu_pkg::*;
#(
  parameter int unsigned W = ALU_W
) (
  input  logic [1:0]   fun,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic [2:0]   cc
);

  logic         sub;
  logic [W-1:0] a_op;
  logic [W-1:0] sum;
  logic [W-1:0] and_r;
  logic [W-1:0] xor_r;
  logic         of;

  // Shared adder handles ADD and SUB (b + ~a + 1); logic units run in parallel.
  always_comb begin
    sub   = (fun == ALU_SUB);
    a_op  = sub ? ~a : a;
    sum   = b + a_op + W'(sub);
    and_r = b & a;
    xor_r = b ^ a;
  end

  // Result select and overflow per operation.
  always_comb begin
    result = sum;
    of     = 1'b0;
    case (fun)
      ALU_ADD: begin
        result = sum;
        of     = (a[W-1] == b[W-1]) & (sum[W-1] != b[W-1]);
      end
      ALU_SUB: begin
        result = sum;
        of     = (a[W-1] != b[W-1]) & (sum[W-1] != b[W-1]);
      end
      ALU_AND: result = and_r;
      default: result = xor_r;
    endcase
  end

  // Condition codes.
  always_comb begin
    cc        = '0;
    cc[CC_ZF] = (result == '0);
    cc[CC_SF] = result[W-1];
    cc[CC_OF] = of;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU among N_REQ requesters with a registered result.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned W     = ALU_W
) (
  input logic                clk,
  input logic                rst_n,
  alu_share_arbiter_if.slave bus
);

  localparam int unsigned IDW = id_width(N_REQ);

  out_state_e     state_q;
  out_state_e     state_d;
  logic [IDW-1:0] last_q;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] cand;
  logic           gnt_any;
  logic           slot_free;
  logic           accept;
  logic           load_en;
  logic [N_REQ-1:0] ready_c;

  logic [1:0]     fun_sel;
  logic [W-1:0]   a_sel;
  logic [W-1:0]   b_sel;
  logic [W-1:0]   alu_res;
  logic [2:0]     alu_cc;

  logic [W-1:0]   data_q;
  logic [2:0]     cc_q;
  logic [IDW-1:0] id_q;

  assign slot_free = (state_q == OUT_EMPTY) | bus.rsp_ready;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IDW'((32'(last_q) + k) % N_REQ);
      if (!gnt_any && bus.req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // One-hot ready to the winner; held low while in reset or the slot is busy.
  always_comb begin
    ready_c = '0;
    if (rst_n && slot_free && gnt_any) begin
      ready_c[gnt_idx] = 1'b1;
    end
  end

  assign bus.req_ready = ready_c;
  assign accept        = |ready_c;

  // Operand mux ahead of the ALU core.
  always_comb begin
    fun_sel = bus.req_fun[2*gnt_idx +: 2];
    a_sel   = bus.req_a[W*gnt_idx +: W];
    b_sel   = bus.req_b[W*gnt_idx +: W];
  end

  alu64_core #(.W(W)) u_core (
    .fun    (fun_sel),
    .a      (a_sel),
    .b      (b_sel),
    .result (alu_res),
    .cc     (alu_cc)
  );

  // Result-slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OUT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Slot next state: accept fills, a lone handshake drains, a stall holds.
  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    case (state_q)
      OUT_EMPTY: begin
        if (accept) begin
          state_d = OUT_FULL;
          load_en = 1'b1;
        end
      end
      OUT_FULL: begin
        if (accept) begin
          state_d = OUT_FULL;
          load_en = 1'b1;
        end else if (bus.rsp_ready) begin
          state_d = OUT_EMPTY;
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  // Result register and round-robin pointer update on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cc_q   <= '0;
      id_q   <= '0;
      last_q <= IDW'(N_REQ - 1);
    end else if (load_en) begin
      data_q <= alu_res;
      cc_q   <= alu_cc;
      id_q   <= gnt_idx;
      last_q <= gnt_idx;
    end
  end

  assign bus.rsp_valid = (state_q == OUT_FULL);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_cc    = cc_q;
  assign bus.rsp_id    = id_q;

endmodule
